// File: rtl/gain_pkg.sv
// Shared definitions for the gain configuration path: stream constants, the parser
// state encoding and the gain word type also used by the gain multiplier.
package gain_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned GAIN_W = 24;
  localparam logic [7:0]  HDR    = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StChan,
    StD2,
    StD1,
    StD0,
    StStore
  } parser_state_e;

  typedef logic [23:0] gain_word_t;

endpackage

// File: rtl/gain_cfg_parser.sv
// Byte-stream parser for gain packets: HDR, channel, gain MSB..LSB.
// Emits a one-cycle store strobe carrying the channel and assembled gain word.
module gain_cfg_parser
  import gain_pkg::*;
#(
  parameter logic [7:0] HDR = gain_pkg::HDR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       err_pulse,
  output logic       store_valid,
  output logic [2:0] store_ch,
  output gain_word_t store_word
);

  parser_state_e state_q, state_d;
  logic [2:0]    ch_q, ch_d;
  gain_word_t    word_q, word_d;
  logic          ready_q;
  logic          err_q, err_d;
  logic          accept;

  assign accept = byte_valid && ready_q;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    word_d  = word_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (byte_in == HDR) state_d = StChan;
          else                err_d   = 1'b1;
        end
      end
      StChan: begin
        if (accept) begin
          if (byte_in[7:3] != 5'd0) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            ch_d    = byte_in[2:0];
            state_d = StD2;
          end
        end
      end
      // Data bytes are taken verbatim, a header value here is just gain data.
      StD2, StD1, StD0: begin
        if (accept) begin
          word_d = {word_q[15:0], byte_in};
          unique case (state_q)
            StD2:    state_d = StD1;
            StD1:    state_d = StD0;
            default: state_d = StStore;
          endcase
        end
      end
      StStore: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Ready is registered off the next state so it drops exactly for the store cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ch_q    <= '0;
      word_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      word_q  <= word_d;
      ready_q <= (state_d != StStore);
      err_q   <= err_d;
    end
  end

  assign byte_ready  = ready_q;
  assign err_pulse   = err_q;
  assign store_valid = (state_q == StStore);
  assign store_ch    = ch_q;
  assign store_word  = word_q;

endmodule

// File: rtl/gain_cfg_writer.sv
// Gain configuration writer: parses packets into per-channel shadow registers and
// flushes dirty channels to config memory, lowest index first, after each data_request.
module gain_cfg_writer
  import gain_pkg::*;
#(
  parameter int unsigned NUM_CH = gain_pkg::NUM_CH,
  parameter int unsigned GAIN_W = gain_pkg::GAIN_W,
  parameter logic [7:0]  HDR    = gain_pkg::HDR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic              data_request,
  output logic [2:0]        config_addr,
  output logic [GAIN_W-1:0] config_data,
  output logic              config_wren,
  output logic              err_pulse,
  output logic              pending
);

  localparam int unsigned PtrW = $clog2(NUM_CH) + 1;

  logic              store_valid;
  logic [2:0]        store_ch;
  gain_word_t        store_word;

  logic [GAIN_W-1:0] shadow_q [NUM_CH];
  logic [NUM_CH-1:0] dirty_q, dirty_d;
  logic              pass_q, pass_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic              pending_q;
  logic              found;
  logic [2:0]        sel;
  logic              wren;

  gain_cfg_parser #(
    .HDR (HDR)
  ) u_parser (
    .clk         (clk),
    .reset       (reset),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .err_pulse   (err_pulse),
    .store_valid (store_valid),
    .store_ch    (store_ch),
    .store_word  (store_word)
  );

  // Lowest dirty channel at or above the scan pointer; indices already passed
  // wait for the next frame.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (dirty_q[i] && (PtrW'(i) >= ptr_q)) begin
        found = 1'b1;
        sel   = 3'(i);
      end
    end
  end

  assign wren = pass_q && found;

  always_comb begin
    dirty_d = dirty_q;
    pass_d  = pass_q;
    ptr_d   = ptr_q;
    if (wren) begin
      dirty_d[sel] = 1'b0;
      ptr_d        = PtrW'(sel) + PtrW'(1);
    end else if (pass_q) begin
      pass_d = 1'b0;
    end
    // A store colliding with the flush of the same channel keeps it dirty.
    if (store_valid) dirty_d[store_ch] = 1'b1;
    if (data_request) begin
      pass_d = 1'b1;
      ptr_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dirty_q   <= '0;
      pass_q    <= 1'b0;
      ptr_q     <= '0;
      pending_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
    end else begin
      dirty_q   <= dirty_d;
      pass_q    <= pass_d;
      ptr_q     <= ptr_d;
      pending_q <= |dirty_d;
      if (store_valid) shadow_q[store_ch] <= store_word;
    end
  end

  assign config_wren = wren;
  assign config_addr = wren ? sel : '0;
  assign config_data = wren ? shadow_q[sel] : '0;
  assign pending     = pending_q;

endmodule

// File: doc/gain_cfg_writer.md
GAIN_CFG_WRITER -- requirements
Module: gain_cfg_writer

Interface
REQ-001 Parameters: NUM_CH, default 8, number of channels; GAIN_W, default 24, gain width; HDR, default 8'hA5, packet header byte.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on posedge.
- reset, in, 1, asynchronous, active-high.
- byte_in, in, 8, config stream byte.
- byte_valid, in, 1, byte_in is valid.
- byte_ready, out, 1, block accepts the byte; transfer occurs when byte_valid && byte_ready.
- data_request, in, 1, frame-start strobe shared with the gain multiplier.
- config_addr, out, 3, config memory write address.
- config_data, out, 24, gain word to write.
- config_wren, out, 1, write strobe, one write per asserted cycle.
- err_pulse, out, 1, one-cycle protocol-error flag.
- pending, out, 1, at least one dirty channel is not yet written.

Function
REQ-003 Packet format: HDR, channel byte, gain[23:16], gain[15:8], gain[7:0]; byte order is MSB first.
REQ-004 Parser states: IDLE, CHAN, D2, D1, D0, STORE. Each accepted byte advances exactly one state.
REQ-005 IDLE: byte == HDR goes to CHAN. Any other byte is dropped, err_pulse fires for 1 cycle, and the state stays IDLE.
REQ-006 CHAN: byte[7:3] != 0 raises err_pulse and returns to IDLE. Otherwise the block latches the channel byte[2:0] and goes to D2.
REQ-007 In D2, D1 and D0, HDR is treated as data, with no resynchronisation.
REQ-008 STORE lasts 1 cycle with byte_ready = 0. It writes the assembled word to shadow[ch], sets dirty[ch], and returns to IDLE. In all other states byte_ready = 1.
REQ-009 A later packet for the same channel before its flush overwrites shadow[ch]; only the last value is written.
REQ-010 A flush pass starts in the cycle after data_request is sampled high. Each cycle it writes the lowest-index dirty channel: config_addr = index, config_data = shadow, config_wren = 1. The dirty bit is cleared in the same cycle.
REQ-011 A pass ends when no dirty bit is set. config_wren stays 0 outside a pass, and there are no writes between frames.
REQ-012 data_request during a pass restarts the scan from index 0. Dirty bits already cleared stay cleared.
REQ-013 STORE and a flush write to the same channel in the same cycle: the write carries the old shadow value, and dirty stays set with the new value.
REQ-014 A packet completing mid-pass for a higher-index channel is written in that same pass. For an already-passed index it is written at the next data_request.
REQ-015 pending = |dirty, registered.
REQ-016 Latency: the first config_wren is 1 cycle after data_request is sampled. N dirty channels complete in N consecutive cycles.
REQ-017 Parser and flush run concurrently. Byte acceptance never stalls for flushing.

Reset
REQ-018 While reset is asserted:
- state = IDLE, all shadow = 0, dirty = 0, channel latch and assembly register = 0.
- byte_ready = 0, config_wren = 0, config_addr = 0, config_data = 0, err_pulse = 0, pending = 0.
REQ-019 byte_ready = 1 from the first clk edge after reset deasserts.
REQ-020 Reset mid-packet or mid-pass discards the partial packet and unflushed data, with no spurious write.

Structure
REQ-021 Package gain_pkg holds:
- NUM_CH, GAIN_W, HDR;
- the parser state enum;
- the gain word typedef logic [23:0], shared with the gain multiplier.
REQ-022 A single sub-module, gain_cfg_parser, holds the byte FSM (REQ-003..REQ-008). It presents a 1-cycle store strobe with {ch, word}. The shadow, dirty mask and flush scanner stay in the top module.

Verification
REQ-023 Bench scenarios:
- Basic: send A5 02 12 34 56, then pulse data_request → exactly one write: addr 2, data 24'h123456, 1 cycle after the strobe; pending goes 1→0.
- Ordering: load ch 5, then ch 1, then ch 7 → after data_request, writes occur in consecutive cycles in order 1, 5, 7.
- Errors: bytes 00 then A5 09 → err_pulse twice; the parser returns to IDLE; no dirty bit is set.
- Overwrite and collision: ch 3 = 24'h000001 then ch 3 = 24'hFFFFFF before the strobe → a single write of FFFFFF. Then force STORE of ch 0 = 24'hABCDEF in the write cycle of ch 0 → the old value is written, and at the next strobe ABCDEF is written.
- Restart and reset: data_request while writing the 3rd of 6 dirty channels → the scan restarts at the lowest remaining index, and every channel is written exactly once. Assert reset mid-packet → no writes occur, and outputs match REQ-018.
